// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default geometry of the register file and a byte-merge helper
// used both by the storage write path and by the same-cycle read bypass.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // The merge helper works on a fixed maximum width; callers zero-extend
    // their operands and truncate the result back to DATA_W.
    localparam int MERGE_W    = 256;
    localparam int MERGE_BE_W = MERGE_W / 8;

    // Bytes whose enable bit is set come from new_v, the rest from old_v.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]    old_v,
        input logic [MERGE_W-1:0]    new_v,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] r;
        r = old_v;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write, reservation and flush signals of the register file.
// Latency: n/a (wiring only).
// Backpressure: reservations stall on rsv_ready; writes are always accepted.
//
// master: pipeline side (decode/writeback); slave: the register file.
// rn/q are NUM_RD ports packed at k*ADDR_W / k*DATA_W.
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    logic [NUM_RD*ADDR_W-1:0] rn;
    logic [NUM_RD*DATA_W-1:0] q;
    logic [NUM_RD-1:0]        busy_o;
    logic                     we;
    logic [ADDR_W-1:0]        wn;
    logic [DATA_W-1:0]        d;
    logic [DATA_W/8-1:0]      wbe;
    logic                     rsv;
    logic [ADDR_W-1:0]        rsv_wn;
    logic                     rsv_ready;
    logic                     flush;

    modport master (
        output rn, we, wn, d, wbe, rsv, rsv_wn, flush,
        input  q, busy_o, rsv_ready
    );

    modport slave (
        input  rn, we, wn, d, wbe, rsv, rsv_wn, flush,
        output q, busy_o, rsv_ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservation, cleared by write/flush.
// Latency: busy updates visible one edge later; rsv_ready is combinational.
// Backpressure: rsv_ready drops while the target is busy (WAW) or during flush.
//
// Ports: clk, clrn (sync, active-high), wr_en/wn (qualified write, wn!=0),
// rsv/rsv_wn (reservation request), flush, busy (full vector), rsv_ready.
// REGFILE_BYPASS_EN: a write landing on rsv_wn this cycle also frees it for
// reservation.
module regfile_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wn,
    input  logic                 rsv,
    input  logic [ADDR_W-1:0]    rsv_wn,
    input  logic                 flush,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 rsv_ready
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_nxt;
    logic             rsv_acc;

    always_comb begin
        rsv_ready = 1'b0;
        if (flush) begin
            rsv_ready = 1'b0;
        end else if (rsv_wn == '0) begin
            rsv_ready = 1'b1;
        end else if (!busy[rsv_wn]) begin
            rsv_ready = 1'b1;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en && (wn == rsv_wn)) begin
            rsv_ready = 1'b1;
`endif
        end
    end

    // Reserving r0 is accepted but has no effect.
    assign rsv_acc = rsv && rsv_ready && (rsv_wn != '0);

    // Reservation is applied after the write clear so it wins on a collision.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wn] = 1'b0;
        end
        if (rsv_acc) begin
            busy_nxt[rsv_wn] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes and pending-write scoreboard.
// Latency: reads 0 cycles (combinational); writes/busy visible one edge later.
// Backpressure: writes always accepted; reservations gated by bus.rsv_ready.
//
// Ports: clk, clrn (sync, active-high, clears data and busy), bus (slave
// modport of regfile_mp_if: rn/q/busy_o read ports, we/wn/d/wbe write port,
// rsv/rsv_wn/rsv_ready reservation, flush).
// REGFILE_BYPASS_EN: forwards a same-cycle write to matching read ports.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input logic         clk,
    input logic         clrn,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_merged;
    logic                     rsv_ready;
    logic [NUM_RD*DATA_W-1:0] q_flat;
    logic [NUM_RD-1:0]        busy_flat;

    assign wr_en     = bus.we && (bus.wn != '0);
    assign wr_merged = DATA_W'(byte_merge(MERGE_W'(mem[bus.wn]),
                                          MERGE_W'(bus.d),
                                          MERGE_BE_W'(bus.wbe)));

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.wn] <= wr_merged;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .clrn      (clrn),
        .wr_en     (wr_en),
        .wn        (bus.wn),
        .rsv       (bus.rsv),
        .rsv_wn    (bus.rsv_wn),
        .flush     (bus.flush),
        .busy      (busy),
        .rsv_ready (rsv_ready)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] q_k;
        logic              busy_k;

        assign idx = bus.rn[k*ADDR_W +: ADDR_W];

        always_comb begin
            q_k    = mem[idx];
            busy_k = busy[idx];
            if (idx == '0) begin
                q_k    = '0;
                busy_k = 1'b0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en && (bus.wn == idx)) begin
                // The landing write retires the reservation, so not busy.
                q_k    = wr_merged;
                busy_k = 1'b0;
`endif
            end
        end

        assign q_flat[k*DATA_W +: DATA_W] = q_k;
        assign busy_flat[k]               = busy_k;
    end

    assign bus.q         = q_flat;
    assign bus.busy_o    = busy_flat;
    assign bus.rsv_ready = rsv_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32-bit, 32 entries, 2 read ports).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Expected values follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic clk;
    logic clrn;
    int   errors;
    int   checks;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.rn     = '0;
        bus.we     = 1'b0;
        bus.wn     = '0;
        bus.d      = '0;
        bus.wbe    = '0;
        bus.rsv    = 1'b0;
        bus.rsv_wn = '0;
        bus.flush  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        clrn = 1'b1;
        tick();
        clrn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rn = {5'(31 - i), 5'(i)};
            bus.rsv_wn = 5'(i);
            #1;
            checks++;
            if (bus.q !== 64'h0) begin
                errors++;
                $display("FAIL reset_q idx=%0d got=%h exp=0", i, bus.q);
            end
            checks++;
            if (bus.busy_o !== 2'b00) begin
                errors++;
                $display("FAIL reset_busy idx=%0d got=%b exp=00", i, bus.busy_o);
            end
            checks++;
            if (bus.rsv_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_rsv_ready idx=%0d got=%b exp=1", i, bus.rsv_ready);
            end
        end
        idle();
    endtask

    task automatic test_byte_write();
        bus.we = 1'b1; bus.wn = 5'd5; bus.d = 32'h11223344; bus.wbe = 4'hF;
        tick();
        bus.d = 32'hAABBCCDD; bus.wbe = 4'b0101;
        tick();
        idle();
        bus.rn = {5'd0, 5'd5};
        #1;
        checks++;
        if (bus.q[31:0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_write got=%h exp=11bb33dd", bus.q[31:0]);
        end
        // wbe=0 leaves data untouched
        bus.we = 1'b1; bus.wn = 5'd5; bus.d = 32'hFFFFFFFF; bus.wbe = 4'h0;
        tick();
        idle();
        bus.rn = {5'd5, 5'd0};
        #1;
        checks++;
        if (bus.q[63:32] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL wbe_zero got=%h exp=11bb33dd", bus.q[63:32]);
        end
    endtask

    task automatic test_r0();
        bus.we = 1'b1; bus.wn = 5'd0; bus.d = 32'hFFFFFFFF; bus.wbe = 4'hF;
        bus.rsv = 1'b1; bus.rsv_wn = 5'd0;
        #1;
        checks++;
        if (bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_rsv_ready_pre got=%b exp=1", bus.rsv_ready);
        end
        tick();
        idle();
        bus.rn = {5'd0, 5'd0};
        #1;
        checks++;
        if (bus.q !== 64'h0) begin
            errors++;
            $display("FAIL r0_q got=%h exp=0", bus.q);
        end
        checks++;
        if (bus.busy_o !== 2'b00) begin
            errors++;
            $display("FAIL r0_busy got=%b exp=00", bus.busy_o);
        end
        checks++;
        if (bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_rsv_ready_post got=%b exp=1", bus.rsv_ready);
        end
    endtask

    task automatic test_scoreboard();
        logic       exp_busy_wr;
        logic       exp_rdy_wr;
        bus.rsv = 1'b1; bus.rsv_wn = 5'd7;
        #1;
        checks++;
        if (bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_first_rsv_ready got=%b exp=1", bus.rsv_ready);
        end
        tick();
        idle();
        bus.rn = {5'd7, 5'd5};
        bus.rsv_wn = 5'd7;
        #1;
        checks++;
        if (bus.busy_o !== 2'b10) begin
            errors++;
            $display("FAIL sb_busy_after_rsv got=%b exp=10", bus.busy_o);
        end
        checks++;
        if (bus.rsv_ready !== 1'b0) begin
            errors++;
            $display("FAIL sb_waw_stall got=%b exp=0", bus.rsv_ready);
        end
        // Write r7 while still reading it and probing reservation.
`ifdef REGFILE_BYPASS_EN
        exp_busy_wr = 1'b0;
        exp_rdy_wr  = 1'b1;
`else
        exp_busy_wr = 1'b1;
        exp_rdy_wr  = 1'b0;
`endif
        bus.we = 1'b1; bus.wn = 5'd7; bus.d = 32'h00000077; bus.wbe = 4'hF;
        #1;
        checks++;
        if (bus.busy_o[1] !== exp_busy_wr) begin
            errors++;
            $display("FAIL sb_busy_during_wr got=%b exp=%b", bus.busy_o[1], exp_busy_wr);
        end
        checks++;
        if (bus.rsv_ready !== exp_rdy_wr) begin
            errors++;
            $display("FAIL sb_rdy_during_wr got=%b exp=%b", bus.rsv_ready, exp_rdy_wr);
        end
        tick();
        idle();
        bus.rn = {5'd7, 5'd5};
        bus.rsv_wn = 5'd7;
        #1;
        checks++;
        if (bus.busy_o !== 2'b00) begin
            errors++;
            $display("FAIL sb_busy_after_wr got=%b exp=00", bus.busy_o);
        end
        checks++;
        if (bus.q[63:32] !== 32'h00000077) begin
            errors++;
            $display("FAIL sb_data_after_wr got=%h exp=00000077", bus.q[63:32]);
        end
        checks++;
        if (bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_rdy_after_wr got=%b exp=1", bus.rsv_ready);
        end
    endtask

    task automatic test_same_cycle();
        bus.we = 1'b1; bus.wn = 5'd9; bus.d = 32'h99990000; bus.wbe = 4'hF;
        bus.rsv = 1'b1; bus.rsv_wn = 5'd9;
        tick();
        idle();
        bus.rn = {5'd9, 5'd9};
        #1;
        checks++;
        if (bus.q[31:0] !== 32'h99990000) begin
            errors++;
            $display("FAIL wr_rsv_data got=%h exp=99990000", bus.q[31:0]);
        end
        checks++;
        if (bus.busy_o !== 2'b11) begin
            errors++;
            $display("FAIL wr_rsv_busy got=%b exp=11", bus.busy_o);
        end
        // Flush + reserve r3 + write r3 in one cycle.
        bus.flush = 1'b1;
        bus.rsv = 1'b1; bus.rsv_wn = 5'd3;
        bus.we = 1'b1; bus.wn = 5'd3; bus.d = 32'h33333333; bus.wbe = 4'hF;
        bus.rn = {5'd9, 5'd3};
        #1;
        checks++;
        if (bus.rsv_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_rsv_ready got=%b exp=0", bus.rsv_ready);
        end
        tick();
        idle();
        bus.rn = {5'd9, 5'd3};
        #1;
        checks++;
        if (bus.busy_o !== 2'b00) begin
            errors++;
            $display("FAIL flush_busy got=%b exp=00", bus.busy_o);
        end
        checks++;
        if (bus.q !== {32'h99990000, 32'h33333333}) begin
            errors++;
            $display("FAIL flush_data got=%h exp=9999000033333333", bus.q);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        bus.we = 1'b1; bus.wn = 5'd4; bus.d = 32'h01020304; bus.wbe = 4'hF;
        tick();
        bus.d = 32'hDEADBEEF;
        bus.rn = {5'd0, 5'd4};
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h01020304;
`endif
        checks++;
        if (bus.q[31:0] !== exp_same) begin
            errors++;
            $display("FAIL bypass_full_same got=%h exp=%h", bus.q[31:0], exp_same);
        end
        tick();
        bus.we = 1'b0;
        #1;
        checks++;
        if (bus.q[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_full_next got=%h exp=deadbeef", bus.q[31:0]);
        end
        // Partial write: the forwarded value must be the byte-merged one.
        bus.we = 1'b1; bus.wn = 5'd4; bus.d = 32'h1234CAFE; bus.wbe = 4'b0011;
        bus.rn = {5'd4, 5'd0};
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADCAFE;
`else
        exp_same = 32'hDEADBEEF;
`endif
        checks++;
        if (bus.q[63:32] !== exp_same) begin
            errors++;
            $display("FAIL bypass_part_same got=%h exp=%h", bus.q[63:32], exp_same);
        end
        tick();
        idle();
        bus.rn = {5'd4, 5'd0};
        #1;
        checks++;
        if (bus.q[63:32] !== 32'hDEADCAFE) begin
            errors++;
            $display("FAIL bypass_part_next got=%h exp=deadcafe", bus.q[63:32]);
        end
    endtask

    task automatic test_midreset();
        bus.rsv = 1'b1; bus.rsv_wn = 5'd12;
        tick();
        idle();
        bus.rn = {5'd12, 5'd5};
        #1;
        checks++;
        if (bus.busy_o !== 2'b10) begin
            errors++;
            $display("FAIL midrst_pre_busy got=%b exp=10", bus.busy_o);
        end
        clrn = 1'b1;
        bus.rsv = 1'b1; bus.rsv_wn = 5'd13;
        bus.we = 1'b1; bus.wn = 5'd5; bus.d = 32'h55555555; bus.wbe = 4'hF;
        tick();
        clrn = 1'b0;
        idle();
        bus.rn = {5'd12, 5'd13};
        #1;
        checks++;
        if (bus.busy_o !== 2'b00) begin
            errors++;
            $display("FAIL midrst_busy got=%b exp=00", bus.busy_o);
        end
        bus.rn = {5'd7, 5'd5};
        #1;
        checks++;
        if (bus.q !== 64'h0) begin
            errors++;
            $display("FAIL midrst_data got=%h exp=0", bus.q);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clrn   = 1'b0;
        idle();
        test_reset();
        test_byte_write();
        test_r0();
        test_scoreboard();
        test_same_cycle();
        test_bypass();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
